// File: rtl/wishbone_mem_router_pkg.sv
// Shared definitions for the Wishbone memory router.
//   state_t    : router FSM encoding (IDLE=0, ACTIVE=1, ERROR=2, DRAIN=3)
//   MAX_SLAVES : upper bound on the number of slave ports
package wishbone_mem_router_pkg;

    localparam int MAX_SLAVES = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        ERROR  = 2'd2,
        DRAIN  = 2'd3
    } state_t;

endpackage

// File: rtl/wishbone_mem_decoder.sv
// Combinational address decoder for the Wishbone memory router.
// Ports:
//   adr_i  : master address
//   hit_o  : one-hot slave select, lowest index wins on overlapping windows
//   miss_o : no window contains the address
module wishbone_mem_decoder #(
    parameter int NUM_SLAVES = 2,
    parameter int ADDR_WIDTH = 32,
    parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] MEM_OFFSET = {32'h0080_0000, 32'h0000_0000},
    parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] MEM_SIZE   = {32'h0080_0000, 32'h0080_0000}
) (
    input  logic [ADDR_WIDTH-1:0] adr_i,
    output logic [NUM_SLAVES-1:0] hit_o,
    output logic                  miss_o
);

    logic [NUM_SLAVES-1:0] raw_hit;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SLAVES; gi++) begin : g_win
            // One extra bit so base+size cannot wrap; size 0 never matches.
            logic [ADDR_WIDTH:0] base;
            logic [ADDR_WIDTH:0] limit;
            logic [ADDR_WIDTH:0] adr_ext;
            assign base    = {1'b0, MEM_OFFSET[gi*ADDR_WIDTH +: ADDR_WIDTH]};
            assign limit   = base + {1'b0, MEM_SIZE[gi*ADDR_WIDTH +: ADDR_WIDTH]};
            assign adr_ext = {1'b0, adr_i};
            assign raw_hit[gi] = (adr_ext >= base) && (adr_ext < limit);
        end
    endgenerate

    always_comb begin
        logic taken;
        hit_o = '0;
        taken = 1'b0;
        for (int k = 0; k < NUM_SLAVES; k++) begin
            if (raw_hit[k] && !taken) begin
                hit_o[k] = 1'b1;
                taken    = 1'b1;
            end
        end
    end

    assign miss_o = ~|raw_hit;

endmodule

// File: rtl/wishbone_mem_router.sv
// Single-master, N-slave Wishbone memory interconnect.
// The first strobe of a bus cycle is decoded and the winning slave is locked
// until i_m_cyc drops. Decode misses, lock violations and stalled slaves end
// in a one-cycle o_m_err pulse so the master never hangs.
// Ports:
//   clk, rst                        : clock, asynchronous active-high reset
//   i_m_*                           : master request (we/stb/cyc/sel/adr/dat)
//   o_m_dat, o_m_ack, o_m_err       : master response
//   o_m_int                         : OR of all slave interrupts
//   o_s_*                           : per-slave request, packed slice per slave
//   i_s_ack, i_s_int, i_s_dat       : per-slave response
module wishbone_mem_router
    import wishbone_mem_router_pkg::*;
#(
    parameter int NUM_SLAVES = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] MEM_OFFSET = {32'h0080_0000, 32'h0000_0000},
    parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] MEM_SIZE   = {32'h0080_0000, 32'h0080_0000},
    parameter int TIMEOUT = 255,
    localparam int SEL_WIDTH = DATA_WIDTH / 8
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             i_m_we,
    input  logic                             i_m_stb,
    input  logic                             i_m_cyc,
    input  logic [SEL_WIDTH-1:0]             i_m_sel,
    input  logic [ADDR_WIDTH-1:0]            i_m_adr,
    input  logic [DATA_WIDTH-1:0]            i_m_dat,
    output logic [DATA_WIDTH-1:0]            o_m_dat,
    output logic                             o_m_ack,
    output logic                             o_m_err,
    output logic                             o_m_int,
    output logic [NUM_SLAVES-1:0]            o_s_we,
    output logic [NUM_SLAVES-1:0]            o_s_cyc,
    output logic [NUM_SLAVES-1:0]            o_s_stb,
    output logic [NUM_SLAVES*SEL_WIDTH-1:0]  o_s_sel,
    output logic [NUM_SLAVES*ADDR_WIDTH-1:0] o_s_adr,
    output logic [NUM_SLAVES*DATA_WIDTH-1:0] o_s_dat,
    input  logic [NUM_SLAVES-1:0]            i_s_ack,
    input  logic [NUM_SLAVES-1:0]            i_s_int,
    input  logic [NUM_SLAVES*DATA_WIDTH-1:0] i_s_dat
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT);

    generate
        if (NUM_SLAVES < 1 || NUM_SLAVES > MAX_SLAVES) begin : g_bad_slaves
            $error("wishbone_mem_router: NUM_SLAVES out of range");
        end
        if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
            $error("wishbone_mem_router: TIMEOUT out of range");
        end
    endgenerate

    state_t                state_q, state_d;
    logic [NUM_SLAVES-1:0] sel_q, sel_d;
    logic [CW-1:0]         cnt_q, cnt_d;

    logic [NUM_SLAVES-1:0] hit;
    logic                  miss;
    logic                  fwd;
    logic                  s_ack;
    logic [DATA_WIDTH-1:0] s_dat;

    wishbone_mem_decoder #(
        .NUM_SLAVES (NUM_SLAVES),
        .ADDR_WIDTH (ADDR_WIDTH),
        .MEM_OFFSET (MEM_OFFSET),
        .MEM_SIZE   (MEM_SIZE)
    ) u_dec (
        .adr_i  (i_m_adr),
        .hit_o  (hit),
        .miss_o (miss)
    );

    // Response from the locked slave.
    always_comb begin
        s_ack = |(i_s_ack & sel_q);
        s_dat = '0;
        for (int k = 0; k < NUM_SLAVES; k++) begin
            if (sel_q[k]) begin
                s_dat = s_dat | i_s_dat[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        fwd     = 1'b0;
        o_m_ack = 1'b0;
        o_m_dat = '0;
        o_m_err = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (i_m_cyc && i_m_stb) begin
                    if (miss) begin
                        state_d = ERROR;
                    end else begin
                        sel_d   = hit;
                        cnt_d   = '0;
                        state_d = ACTIVE;
                    end
                end
            end
            ACTIVE: begin
                if (!i_m_cyc) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (i_m_stb && (hit != sel_q)) begin
                    // Strobe left the locked window: abort without forwarding.
                    state_d = ERROR;
                end else begin
                    fwd     = 1'b1;
                    o_m_ack = s_ack;
                    o_m_dat = s_ack ? s_dat : '0;
                    if (!i_m_stb || s_ack) begin
                        cnt_d = '0;
                    end else begin
                        if (cnt_q != CNT_MAX) begin
                            cnt_d = cnt_q + CW'(1);
                        end
                        // Leaving at the edge where the count reaches TIMEOUT
                        // drops the slave strobe in the same cycle err rises.
                        if (cnt_d == CNT_MAX) begin
                            state_d = ERROR;
                        end
                    end
                end
            end
            ERROR: begin
                o_m_err = 1'b1;
                cnt_d   = '0;
                state_d = DRAIN;
            end
            DRAIN: begin
                if (!i_m_cyc) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sel_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SLAVES; gi++) begin : g_slv
            logic en;
            assign en          = fwd & sel_q[gi];
            assign o_s_we[gi]  = en & i_m_we;
            assign o_s_cyc[gi] = en & i_m_cyc;
            assign o_s_stb[gi] = en & i_m_stb;
            assign o_s_sel[gi*SEL_WIDTH  +: SEL_WIDTH]  = en ? i_m_sel : '0;
            assign o_s_adr[gi*ADDR_WIDTH +: ADDR_WIDTH] = en ? i_m_adr : '0;
            assign o_s_dat[gi*DATA_WIDTH +: DATA_WIDTH] = en ? i_m_dat : '0;
        end
    endgenerate

    assign o_m_int = |i_s_int;

endmodule
